// File: rtl/clock_timekeeper_pkg.sv
// Shared definitions for the HH:MM:SS timekeeper: setup FSM states,
// BCD field limits, one-hot field codes and the 24h -> 12h hour mapping.
package clock_timekeeper_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_SET_SEC  = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_HOUR = 2'd3
    } state_e;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    localparam logic [2:0] FIELD_NONE = 3'b000;
    localparam logic [2:0] FIELD_SEC  = 3'b001;
    localparam logic [2:0] FIELD_MIN  = 3'b010;
    localparam logic [2:0] FIELD_HOUR = 3'b100;

    // Maps a BCD hour 00..23 to {pm, hh} in 12-hour form, leading zero kept.
    function automatic logic [8:0] hour_to_12h(input logic [7:0] hour_bcd);
        logic [3:0] ones;
        logic [8:0] result;
        ones = hour_bcd[3:0];
        if (hour_bcd == 8'h00)      result = {1'b0, 8'h12};
        else if (hour_bcd < 8'h12)  result = {1'b0, hour_bcd};
        else if (hour_bcd == 8'h12) result = {1'b1, 8'h12};
        else if (hour_bcd < 8'h20)  result = {1'b1, 4'h0, ones - 4'd2};  // 13..19 -> 01..07
        else if (hour_bcd < 8'h22)  result = {1'b1, 4'h0, ones + 4'd8};  // 20..21 -> 08..09
        else                        result = {1'b1, 4'h1, ones - 4'd2};  // 22..23 -> 10..11
        return result;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX_BCD. i_inc counts up and reports a
// carry on wrap; i_set_up/i_set_down step the value with wrap but no carry.
module bcd_mod_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    input  logic       i_set_up,
    input  logic       i_set_down,
    output logic [7:0] o_value,
    output logic       o_carry
);

    logic [7:0] r_value;
    logic [7:0] w_next;
    logic [7:0] w_plus_one;
    logic [7:0] w_minus_one;
    logic [3:0] w_tens;
    logic [3:0] w_ones;

    assign w_tens = r_value[7:4];
    assign w_ones = r_value[3:0];

    // Digit-wise BCD neighbours of the current value, wrapping at the field limits.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        w_plus_one  = r_value;
        w_minus_one = r_value;
        if (r_value == MAX_BCD)  w_plus_one = 8'h00;
        else if (w_ones == 4'd9) w_plus_one = {w_tens + 4'd1, 4'd0};
        else                     w_plus_one = {w_tens, w_ones + 4'd1};
        if (r_value == 8'h00)    w_minus_one = MAX_BCD;
        else if (w_ones == 4'd0) w_minus_one = {w_tens - 4'd1, 4'd9};
        else                     w_minus_one = {w_tens, w_ones - 4'd1};
    end

    // Selects the next value; up and down together cancel.
    always_comb begin
        w_next = r_value;
        if (i_inc)                         w_next = w_plus_one;
        else if (i_set_up && !i_set_down)  w_next = w_plus_one;
        else if (i_set_down && !i_set_up)  w_next = w_minus_one;
    end

    // Value register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (i_rst) r_value <= 8'h00;
        else       r_value <= w_next;
    end

    assign o_value = r_value;
    assign o_carry = i_inc && (r_value == MAX_BCD);

endmodule

// File: rtl/clock_timekeeper.sv
// HH:MM:SS timekeeper on a single clock: 1 Hz prescaler, setup FSM,
// three chained BCD counters, 12/24-hour mapping and registered outputs.
module clock_timekeeper
    import clock_timekeeper_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int PRESCALE_W  = 26
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        change_mode,
    input  logic        up,
    input  logic        down,
    input  logic        mode_12h,
    output logic [23:0] time_bcd,
    output logic        pm,
    output logic        normal_state,
    output logic [2:0]  set_field,
    output logic        blink,
    output logic        tick_1hz,
    output logic        TC
);

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(CLK_FREQ_HZ - 1);
    localparam logic [PRESCALE_W-1:0] PRESC_HALF = PRESCALE_W'(CLK_FREQ_HZ / 2);

    state_e                r_state;
    state_e                w_state_next;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  w_tick;
    logic                  w_adj_up;
    logic                  w_adj_down;
    logic [2:0]            w_sel;
    logic                  w_inc_sec;
    logic                  w_sec_carry;
    logic                  w_min_carry;
    logic                  w_day_roll;
    logic [7:0]            w_sec;
    logic [7:0]            w_min;
    logic [7:0]            w_hour;
    logic [8:0]            w_hour_12;
    logic [23:0]           r_time_bcd;
    logic                  r_pm;
    logic                  r_tick;
    logic                  r_roll_d;
    logic                  r_tc;

    assign w_tick = (r_presc == PRESC_LAST);

    // Prescaler: free-running in every state, restarted when setup completes.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)                                        r_presc <= '0;
        else if (r_state == ST_SET_HOUR && change_mode)   r_presc <= '0;
        else if (w_tick)                                  r_presc <= '0;
        else                                              r_presc <= r_presc + PRESCALE_W'(1);
    end

    // Setup FSM state register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= ST_NORMAL;
        else       r_state <= w_state_next;
    end

    // Next state and selected field; change_mode takes priority over up/down.
    always_comb begin
        w_state_next = r_state;
        w_sel        = FIELD_NONE;
        case (r_state)
            ST_NORMAL: begin
                if (change_mode) w_state_next = ST_SET_SEC;
            end
            ST_SET_SEC: begin
                w_sel = FIELD_SEC;
                if (change_mode) w_state_next = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                w_sel = FIELD_MIN;
                if (change_mode) w_state_next = ST_SET_HOUR;
            end
            ST_SET_HOUR: begin
                w_sel = FIELD_HOUR;
                if (change_mode) w_state_next = ST_NORMAL;
            end
            default: w_state_next = ST_NORMAL;
        endcase
    end

    assign w_adj_up   = up && !down && !change_mode;
    assign w_adj_down = down && !up && !change_mode;
    assign w_inc_sec  = (r_state == ST_NORMAL) && w_tick;

    bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
        .i_clk      (CLOCK_50),
        .i_rst      (reset),
        .i_inc      (w_inc_sec),
        .i_set_up   (w_sel[0] && w_adj_up),
        .i_set_down (w_sel[0] && w_adj_down),
        .o_value    (w_sec),
        .o_carry    (w_sec_carry)
    );

    bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
        .i_clk      (CLOCK_50),
        .i_rst      (reset),
        .i_inc      (w_sec_carry),
        .i_set_up   (w_sel[1] && w_adj_up),
        .i_set_down (w_sel[1] && w_adj_down),
        .o_value    (w_min),
        .o_carry    (w_min_carry)
    );

    bcd_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hour (
        .i_clk      (CLOCK_50),
        .i_rst      (reset),
        .i_inc      (w_min_carry),
        .i_set_up   (w_sel[2] && w_adj_up),
        .i_set_down (w_sel[2] && w_adj_down),
        .o_value    (w_hour),
        .o_carry    (w_day_roll)
    );

    assign w_hour_12 = hour_to_12h(w_hour);

    // Output registers: display one cycle behind the counters; TC delayed twice
    // so it lines up with the first 00:00:00 on time_bcd.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_time_bcd <= 24'h0;
            r_pm       <= 1'b0;
            r_tick     <= 1'b0;
            r_roll_d   <= 1'b0;
            r_tc       <= 1'b0;
        end else begin
            if (mode_12h) begin
                r_time_bcd <= {w_hour_12[7:0], w_min, w_sec};
                r_pm       <= w_hour_12[8];
            end else begin
                r_time_bcd <= {w_hour, w_min, w_sec};
                r_pm       <= 1'b0;
            end
            r_tick   <= w_tick;
            r_roll_d <= w_day_roll;
            r_tc     <= r_roll_d;
        end
    end

    assign time_bcd     = r_time_bcd;
    assign pm           = r_pm;
    assign tick_1hz     = r_tick;
    assign TC           = r_tc;
    assign normal_state = (r_state != ST_NORMAL);
    assign set_field    = w_sel;
    assign blink        = (r_state != ST_NORMAL) && (r_presc < PRESC_HALF);

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper with a 10-cycle second. A cycle
// model pushes expected outputs into a scoreboard at each rising edge; they
// are popped and compared on the following falling edge.
module tb_clock_timekeeper;

    localparam int F = 10;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        change_mode = 1'b0;
    logic        up = 1'b0;
    logic        down = 1'b0;
    logic        mode_12h = 1'b0;
    logic [23:0] time_bcd;
    logic        pm;
    logic        normal_state;
    logic [2:0]  set_field;
    logic        blink;
    logic        tick_1hz;
    logic        TC;

    always #5 CLOCK_50 = ~CLOCK_50;

    clock_timekeeper #(.CLK_FREQ_HZ(F), .PRESCALE_W(4)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .change_mode  (change_mode),
        .up           (up),
        .down         (down),
        .mode_12h     (mode_12h),
        .time_bcd     (time_bcd),
        .pm           (pm),
        .normal_state (normal_state),
        .set_field    (set_field),
        .blink        (blink),
        .tick_1hz     (tick_1hz),
        .TC           (TC)
    );

    typedef struct packed {
        logic [23:0] time_bcd;
        logic        pm;
        logic        normal_state;
        logic [2:0]  set_field;
        logic        blink;
        logic        tick;
        logic        tc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model state: time held as plain integers.
    int          m_state, m_presc, m_h, m_m, m_s;
    logic        m_tick, m_roll_d, m_tc, m_pm;
    logic [23:0] m_time;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] disp_hh(input int h, input logic m12);
        int h12;
        if (!m12) return bcd2(h);
        h12 = h % 12;
        if (h12 == 0) h12 = 12;
        return bcd2(h12);
    endfunction

    function automatic exp_t expected();
        exp_t e;
        e.time_bcd     = m_time;
        e.pm           = m_pm;
        e.normal_state = (m_state != 0);
        e.set_field    = (m_state == 1) ? 3'b001 : (m_state == 2) ? 3'b010 :
                         (m_state == 3) ? 3'b100 : 3'b000;
        e.blink        = (m_state != 0) && (m_presc < F / 2);
        e.tick         = m_tick;
        e.tc           = m_tc;
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0; m_presc = 0; m_h = 0; m_m = 0; m_s = 0;
        m_tick = 0; m_roll_d = 0; m_tc = 0; m_pm = 0; m_time = '0;
    endtask

    task automatic model_edge(input logic cm, input logic u, input logic d, input logic m12);
        logic tick;
        logic roll;
        int   np;
        int   stp;
        roll   = 1'b0;
        tick   = (m_presc == F - 1);
        m_time = {disp_hh(m_h, m12), bcd2(m_m), bcd2(m_s)};
        m_pm   = m12 && (m_h >= 12);
        m_tc   = m_roll_d;
        np     = (m_state == 3 && cm) ? 0 : (tick ? 0 : m_presc + 1);
        if (m_state == 0) begin
            if (tick) begin
                m_s++;
                if (m_s == 60) begin
                    m_s = 0; m_m++;
                    if (m_m == 60) begin
                        m_m = 0; m_h++;
                        if (m_h == 24) begin m_h = 0; roll = 1'b1; end
                    end
                end
            end
        end else if (!cm && (u != d)) begin
            stp = u ? 1 : -1;
            case (m_state)
                1: m_s = (m_s + stp + 60) % 60;
                2: m_m = (m_m + stp + 60) % 60;
                default: m_h = (m_h + stp + 24) % 24;
            endcase
        end
        m_roll_d = roll;
        m_tick   = tick;
        m_presc  = np;
        if (cm) m_state = (m_state + 1) % 4;
    endtask

    task automatic compare_head();
        exp_t e;
        check("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("time_bcd", 32'(time_bcd), 32'(e.time_bcd));
            check("pm", 32'(pm), 32'(e.pm));
            check("normal_state", 32'(normal_state), 32'(e.normal_state));
            check("set_field", 32'(set_field), 32'(e.set_field));
            check("blink", 32'(blink), 32'(e.blink));
            check("tick_1hz", 32'(tick_1hz), 32'(e.tick));
            check("TC", 32'(TC), 32'(e.tc));
        end
    endtask

    // One clock: drive inputs, model the edge, compare on the falling edge.
    task automatic cycle(input logic cm, input logic u, input logic d);
        change_mode = cm; up = u; down = d;
        @(posedge CLOCK_50);
        model_edge(cm, u, d, mode_12h);
        sb_q.push_back(expected());
        @(negedge CLOCK_50);
        compare_head();
        change_mode = 1'b0; up = 1'b0; down = 1'b0;
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge CLOCK_50);
        #2 reset = 1'b1;
        change_mode = 1'b0; up = 1'b0; down = 1'b0;
        model_reset();
        #1 sb_q.push_back(expected());
        compare_head();
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic cycles_to_tick(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 2 * F; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (tick_1hz) begin n = i; break; end
        end
        check(tag, 32'(n), 32'(F));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc_count;
        int s_before;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        sb_q.push_back(expected());
        compare_head();
        reset = 1'b0;

        // 1. mid-second reset, then first tick after F cycles
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        do_reset();
        cycles_to_tick("tick_after_reset");

        // 2. set 23:59:58 and roll the day
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        check("preset_display", 32'(time_bcd), 32'h235958);
        tc_count = 0;
        for (int i = 0; i < 2 * F + 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (TC) begin
                tc_count++;
                check("tc_time_zero", 32'(time_bcd), 32'h000000);
            end
        end
        check("tc_pulses", 32'(tc_count), 32'd1);

        // 3. 12-hour mapping of hours 00, 12, 13 and mode toggle latency
        mode_12h = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        check("h00_12h_hh", 32'(time_bcd[23:16]), 32'h12);
        check("h00_12h_pm", 32'(pm), 32'd0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("h12_12h_hh", 32'(time_bcd[23:16]), 32'h12);
        check("h12_12h_pm", 32'(pm), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("h13_12h_hh", 32'(time_bcd[23:16]), 32'h01);
        check("h13_12h_pm", 32'(pm), 32'd1);
        mode_12h = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        check("h13_24h_hh", 32'(time_bcd[23:16]), 32'h13);
        check("h13_24h_pm", 32'(pm), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);

        // 4. minute wrap without carry, up+down cancel, frozen time in setup
        do_reset();
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("min_wrap_down", 32'(time_bcd), 32'h005900);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("up_down_cancel", 32'(time_bcd), 32'h005900);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        check("frozen_in_setup", 32'(time_bcd), 32'h005900);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);

        // 5. four change_mode pulses walk the fields, prescaler restarts
        cycle(1'b1, 1'b0, 1'b0);
        check("sf_sec", 32'(set_field), 32'b001);
        check("ns_sec", 32'(normal_state), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        check("sf_min", 32'(set_field), 32'b010);
        check("ns_min", 32'(normal_state), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        check("sf_hour", 32'(set_field), 32'b100);
        check("ns_hour", 32'(normal_state), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        check("sf_normal", 32'(set_field), 32'b000);
        check("ns_normal", 32'(normal_state), 32'd0);
        cycles_to_tick("tick_after_setup");

        // 6. change_mode with up in SET_SEC: FSM advances, seconds untouched
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("cm_up_seconds", 32'(time_bcd[7:0]), 32'h01);
        check("cm_up_field", 32'(set_field), 32'b010);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);

        // 7. tick on the cycle change_mode leaves NORMAL is still applied
        for (int i = 0; i < F && m_presc != F - 1; i++) cycle(1'b0, 1'b0, 1'b0);
        s_before = m_s;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("tick_on_exit", 32'(time_bcd[7:0]), 32'(bcd2((s_before + 1) % 60)));
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
